// File: rtl/laser_point_feeder.sv
// Buffers one frame of host points, pulses a core restart, then streams the frame one point per cycle.
// Latency: restart 1 cycle after the last handshake; the stream follows on the next NPTS cycles. The host is held off (IN_READY=0) until CORE_DONE or a timeout.
module laser_point_feeder #(
   parameter int NPTS    = 40,
   parameter int CW      = 4,
   parameter int TIMEOUT = 4095
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          IN_VALID,
   input  logic [CW-1:0] IN_X,
   input  logic [CW-1:0] IN_Y,
   output logic          IN_READY,
   output logic          CORE_RST,
   output logic [CW-1:0] OUT_X,
   output logic [CW-1:0] OUT_Y,
   output logic          OUT_VALID,
   output logic          OUT_FIRST,
   output logic          OUT_LAST,
   input  logic          CORE_DONE,
   output logic          BUSY,
   output logic [7:0]    FRAME_CNT,
   output logic          ERR
);

   localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(NPTS - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_FILL, S_RESTART, S_STREAM, S_WAIT} state_t;

   state_t          state_q;
   logic [2*CW-1:0] mem_q [NPTS];
   logic [PW-1:0]   wptr_q, rptr_q;
   logic [TW-1:0]   tcnt_q;
   logic            in_ready_q, core_rst_q;
   logic            out_valid_q, out_first_q, out_last_q;
   logic [CW-1:0]   out_x_q, out_y_q;
   logic [7:0]      frame_cnt_q;
   logic            err_q;
   logic            push_d;

   assign push_d = RST_N && (state_q == S_FILL) && IN_VALID && in_ready_q;

   always_ff @(posedge CLK) begin
      if (push_d) mem_q[wptr_q] <= {IN_X, IN_Y};
   end

   // Output registers are loaded one state ahead so the first point lands right after RESTART.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= S_FILL;
         wptr_q      <= '0;
         rptr_q      <= '0;
         tcnt_q      <= '0;
         in_ready_q  <= 1'b1;
         core_rst_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         frame_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         core_rst_q <= 1'b0;
         case (state_q)
            S_FILL: begin
               if (push_d) begin
                  if (wptr_q == LAST_IDX) begin
                     wptr_q     <= '0;
                     in_ready_q <= 1'b0;
                     core_rst_q <= 1'b1;
                     state_q    <= S_RESTART;
                  end else begin
                     wptr_q <= wptr_q + 1'b1;
                  end
               end
            end
            S_RESTART: begin
               {out_x_q, out_y_q} <= mem_q[0];
               out_valid_q <= 1'b1;
               out_first_q <= 1'b1;
               out_last_q  <= (LAST_IDX == '0);
               rptr_q      <= PW'(1);
               state_q     <= S_STREAM;
            end
            S_STREAM: begin
               if (out_last_q) begin
                  out_valid_q <= 1'b0;
                  out_first_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  rptr_q      <= '0;
                  state_q     <= S_WAIT;
               end else begin
                  {out_x_q, out_y_q} <= mem_q[rptr_q];
                  out_first_q <= 1'b0;
                  out_last_q  <= (rptr_q == LAST_IDX);
                  rptr_q      <= (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
               end
            end
            S_WAIT: begin
               if (CORE_DONE) begin
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  tcnt_q      <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_FILL;
               end else if (tcnt_q == TO_LAST) begin
                  err_q      <= 1'b1;
                  tcnt_q     <= '0;
                  in_ready_q <= 1'b1;
                  state_q    <= S_FILL;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            default: state_q <= S_FILL;
         endcase
      end
   end

   assign IN_READY  = in_ready_q;
   assign CORE_RST  = core_rst_q;
   assign OUT_X     = out_x_q;
   assign OUT_Y     = out_y_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_FIRST = out_first_q;
   assign OUT_LAST  = out_last_q;
   assign BUSY      = (state_q != S_FILL);
   assign FRAME_CNT = frame_cnt_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Directed bench for laser_point_feeder: fill, stream, backpressure, timeout, done/timeout race, mid-stream reset.
module tb_laser_point_feeder;

   logic       CLK = 1'b0;
   logic       RST_N, IN_VALID, CORE_DONE;
   logic [3:0] IN_X, IN_Y;
   logic       IN_READY, CORE_RST, OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, ERR;
   logic [3:0] OUT_X, OUT_Y;
   logic [7:0] FRAME_CNT;

   int checks = 0;
   int errors = 0;
   int exp_frames = 0;

   laser_point_feeder #(.NPTS(40), .CW(4), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_X(IN_X), .IN_Y(IN_Y),
      .IN_READY(IN_READY), .CORE_RST(CORE_RST), .OUT_X(OUT_X), .OUT_Y(OUT_Y),
      .OUT_VALID(OUT_VALID), .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST),
      .CORE_DONE(CORE_DONE), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [3:0] px(input int s, input int i);
      if (s == 0) return 4'(i % 16);
      return 4'((i * (2 * s + 1) + s) % 16);
   endfunction

   function automatic logic [3:0] py(input int s, input int i);
      if (s == 0) return 4'(15 - (i % 16));
      return 4'((i * s + 7) % 16);
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic fill_frame(input int s, input bit bursty);
      int n = 0;
      int guard = 0;
      bit v;
      while (n < 40 && guard < 400) begin
         v = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
         IN_VALID = v;
         IN_X = v ? px(s, n) : ~px(s, n);
         IN_Y = v ? py(s, n) : ~py(s, n);
         if (v) begin
            checks++;
            if (IN_READY !== 1'b1) begin
               errors++;
               $display("FAIL fill_ready s=%0d n=%0d: got %b want 1", s, n, IN_READY);
            end
         end
         step();
         if (v) n++;
         guard++;
      end
      IN_VALID = 1'b0;
      checks++;
      if ({CORE_RST, IN_READY, BUSY} !== 3'b101) begin
         errors++;
         $display("FAIL restart s=%0d: got rst/rdy/busy=%b want 101", s, {CORE_RST, IN_READY, BUSY});
      end
   endtask

   task automatic run_stream(input int s, input int done_at, input int hold_s, input int stop_at);
      logic [10:0] exp_v;
      if (hold_s >= 0) begin
         IN_VALID = 1'b1;
         IN_X = px(hold_s, 0);
         IN_Y = py(hold_s, 0);
      end
      for (int i = 0; i < 40; i++) begin
         step();
         CORE_DONE = (i == done_at);
         exp_v = {1'b1, (i == 0), (i == 39), px(s, i), py(s, i)};
         checks++;
         if ({OUT_VALID, OUT_FIRST, OUT_LAST, OUT_X, OUT_Y} !== exp_v) begin
            errors++;
            $display("FAIL stream s=%0d i=%0d: got %h want %h", s, i,
                     {OUT_VALID, OUT_FIRST, OUT_LAST, OUT_X, OUT_Y}, exp_v);
         end
         checks++;
         if ({CORE_RST, IN_READY, BUSY} !== 3'b001 || FRAME_CNT !== 8'(exp_frames)) begin
            errors++;
            $display("FAIL stream_ctl s=%0d i=%0d: got rst/rdy/busy=%b cnt=%0d want 001 cnt=%0d",
                     s, i, {CORE_RST, IN_READY, BUSY}, FRAME_CNT, exp_frames);
         end
         if (i == stop_at) begin
            RST_N = 1'b0;
            return;
         end
      end
      CORE_DONE = 1'b0;
   endtask

   task automatic wait_entry(input int s);
      step();
      checks++;
      if ({OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, IN_READY} !== 5'b00010 ||
          {OUT_X, OUT_Y} !== {px(s, 39), py(s, 39)}) begin
         errors++;
         $display("FAIL wait_entry s=%0d: got v/f/l/busy/rdy=%b xy=%h want 00010 xy=%h", s,
                  {OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, IN_READY}, {OUT_X, OUT_Y}, {px(s, 39), py(s, 39)});
      end
   endtask

   task automatic pulse_done(input string name);
      CORE_DONE = 1'b1;
      step();
      CORE_DONE = 1'b0;
      exp_frames++;
      checks++;
      if (FRAME_CNT !== 8'(exp_frames) || {IN_READY, BUSY} !== 2'b10) begin
         errors++;
         $display("FAIL %s_done: got cnt=%0d rdy/busy=%b want cnt=%0d 10", name, FRAME_CNT,
                  {IN_READY, BUSY}, exp_frames);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; IN_VALID = 1'b0; CORE_DONE = 1'b0; IN_X = '0; IN_Y = '0;
      step(); step();
      checks++;
      if ({IN_READY, CORE_RST, OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, ERR} !== 7'b1000000 ||
          {OUT_X, OUT_Y} !== 8'h00 || FRAME_CNT !== 8'd0) begin
         errors++;
         $display("FAIL reset: got flags=%b xy=%h cnt=%0d want 1000000 00 0",
                  {IN_READY, CORE_RST, OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, ERR}, {OUT_X, OUT_Y}, FRAME_CNT);
      end
      RST_N = 1'b1;
      step();
      checks++;
      if ({IN_READY, BUSY} !== 2'b10) begin
         errors++;
         $display("FAIL reset_idle: got rdy/busy=%b want 10", {IN_READY, BUSY});
      end
   endtask

   task automatic test_fill_stream();
      fill_frame(0, 1'b0);
      run_stream(0, -1, -1, -1);
      wait_entry(0);
      pulse_done("fill_stream");
   endtask

   // Frame 1 is bursty; a frame-2 point is held on the bus from stream start and must land at index 0.
   task automatic test_backpressure();
      fill_frame(1, 1'b1);
      run_stream(1, 39, 2, -1);
      wait_entry(1);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (IN_READY !== 1'b0 || FRAME_CNT !== 8'(exp_frames)) begin
            errors++;
            $display("FAIL bp_wait k=%0d: got rdy=%b cnt=%0d want 0 cnt=%0d", k, IN_READY, FRAME_CNT, exp_frames);
         end
      end
      pulse_done("backpressure");
   endtask

   task automatic test_simultaneous();
      fill_frame(2, 1'b0);
      run_stream(2, -1, -1, -1);
      wait_entry(2);
      for (int k = 1; k <= 15; k++) step();
      pulse_done("simultaneous");
      checks++;
      if (ERR !== 1'b0) begin
         errors++;
         $display("FAIL simultaneous_err: got %b want 0", ERR);
      end
   endtask

   task automatic test_timeout();
      fill_frame(3, 1'b0);
      run_stream(3, -1, -1, -1);
      wait_entry(3);
      for (int k = 1; k <= 15; k++) begin
         step();
         checks++;
         if ({ERR, BUSY} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_wait k=%0d: got err/busy=%b want 01", k, {ERR, BUSY});
         end
      end
      step();
      checks++;
      if ({ERR, BUSY, IN_READY} !== 3'b101 || FRAME_CNT !== 8'(exp_frames)) begin
         errors++;
         $display("FAIL timeout_fire: got err/busy/rdy=%b cnt=%0d want 101 cnt=%0d",
                  {ERR, BUSY, IN_READY}, FRAME_CNT, exp_frames);
      end
      fill_frame(4, 1'b1);
      run_stream(4, -1, -1, -1);
      wait_entry(4);
      pulse_done("after_timeout");
      checks++;
      if (ERR !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b want 1", ERR);
      end
   endtask

   task automatic test_reset_mid();
      fill_frame(5, 1'b0);
      run_stream(5, -1, -1, 20);
      step();
      RST_N = 1'b1;
      exp_frames = 0;
      checks++;
      if ({OUT_VALID, IN_READY, BUSY, ERR, CORE_RST} !== 5'b01000 || FRAME_CNT !== 8'd0 ||
          {OUT_X, OUT_Y} !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: got v/rdy/busy/err/rst=%b cnt=%0d xy=%h want 01000 0 00",
                  {OUT_VALID, IN_READY, BUSY, ERR, CORE_RST}, FRAME_CNT, {OUT_X, OUT_Y});
      end
      fill_frame(6, 1'b0);
      run_stream(6, -1, -1, -1);
      wait_entry(6);
      pulse_done("after_reset");
   endtask

   initial begin
      test_reset();
      test_fill_stream();
      test_backpressure();
      test_simultaneous();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
